// File: rtl/dec_trigger_csr_if.sv
// Trigger packet type and the CSR access bus shared by the core and the trigger CSR block.
package dec_trigger_csr_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } trigger_pkt_t;
endpackage

interface dec_trigger_csr_if;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;

    modport master (
        output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
        input  csr_rd_data
    );

    modport slave (
        input  csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
        output csr_rd_data
    );
endinterface

// File: rtl/dec_trigger_csr.sv
// Four mcontrol-style triggers: tselect/tdata1/tdata2 state, chain-pair hit
// qualification, sticky hit bits and registered debug/breakpoint requests.
module dec_trigger_csr
    import dec_trigger_csr_pkg::*;
(
    input  logic               clk,
    input  logic               rst_l,
    dec_trigger_csr_if.slave   csr,
    input  logic               dbg_mode,
    input  logic [3:0]         i0_trigger_hit_r,
    input  logic [3:0]         i1_trigger_hit_r,
    output trigger_pkt_t [3:0] trigger_pkt_any,
    output logic [3:0]         trigger_hit_r,
    output logic               dbg_trigger_req,
    output logic               brkpt_exc_req
);
    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

    logic [1:0]  r_tselect;
    logic [3:0]  r_dmode;
    logic [3:0]  r_hit;
    logic [3:0]  r_select;
    logic [3:0]  r_action;
    logic [3:0]  r_chain;
    logic [3:0]  r_match;
    logic [3:0]  r_m;
    logic [3:0]  r_execute;
    logic [3:0]  r_store;
    logic [3:0]  r_load;
    logic [31:0] r_tdata2 [4];

    logic [3:0]  r_hit_out;
    logic        r_dbg_req;
    logic        r_brk_req;

    logic        w_lock;
    logic        w_wr_tsel;
    logic        w_wr_tdata1;
    logic        w_wr_tdata2;
    logic [3:0]  w_q_i0;
    logic [3:0]  w_q_i1;
    logic [3:0]  w_q;
    logic [3:0]  w_hit_nxt;
    logic        w_dbg_nxt;
    logic        w_brk_nxt;
    logic [31:0] w_tdata1_rd;

    // A trigger owned by debug mode cannot be reprogrammed from normal mode.
    assign w_lock      = r_dmode[r_tselect] & ~dbg_mode;
    assign w_wr_tsel   = csr.csr_wr_en & (csr.csr_wr_addr == ADDR_TSELECT);
    assign w_wr_tdata1 = csr.csr_wr_en & (csr.csr_wr_addr == ADDR_TDATA1) & ~w_lock;
    assign w_wr_tdata2 = csr.csr_wr_en & (csr.csr_wr_addr == ADDR_TDATA2) & ~w_lock;

    // Chaining only pairs hits from the same retiring slot.
    always_comb begin
        w_q_i0[0] = i0_trigger_hit_r[0] & (~r_chain[0] | i0_trigger_hit_r[1]);
        w_q_i0[1] = i0_trigger_hit_r[1] & (~r_chain[0] | i0_trigger_hit_r[0]);
        w_q_i0[2] = i0_trigger_hit_r[2] & (~r_chain[2] | i0_trigger_hit_r[3]);
        w_q_i0[3] = i0_trigger_hit_r[3] & (~r_chain[2] | i0_trigger_hit_r[2]);
        w_q_i1[0] = i1_trigger_hit_r[0] & (~r_chain[0] | i1_trigger_hit_r[1]);
        w_q_i1[1] = i1_trigger_hit_r[1] & (~r_chain[0] | i1_trigger_hit_r[0]);
        w_q_i1[2] = i1_trigger_hit_r[2] & (~r_chain[2] | i1_trigger_hit_r[3]);
        w_q_i1[3] = i1_trigger_hit_r[3] & (~r_chain[2] | i1_trigger_hit_r[2]);
        w_q       = w_q_i0 | w_q_i1;
    end

    always_comb begin
        w_hit_nxt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_hit_nxt[i] = ((w_wr_tdata1 && (r_tselect == 2'(i))) ? csr.csr_wr_data[20] : r_hit[i])
                           | w_q[i];
        end
        w_dbg_nxt = |(w_q & r_action & r_dmode);
        w_brk_nxt = |(w_q & (~r_action | ~r_dmode));
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_tselect <= '0;
            r_dmode   <= '0;
            r_hit     <= '0;
            r_select  <= '0;
            r_action  <= '0;
            r_chain   <= '0;
            r_match   <= '0;
            r_m       <= '0;
            r_execute <= '0;
            r_store   <= '0;
            r_load    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_tdata2[i] <= '0;
            end
            r_hit_out <= '0;
            r_dbg_req <= 1'b0;
            r_brk_req <= 1'b0;
        end else begin
            if (w_wr_tsel) begin
                r_tselect <= csr.csr_wr_data[1:0];
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_wr_tdata1 && (r_tselect == 2'(i))) begin
                    r_select[i]  <= csr.csr_wr_data[19];
                    r_action[i]  <= csr.csr_wr_data[12];
                    r_match[i]   <= csr.csr_wr_data[7];
                    r_m[i]       <= csr.csr_wr_data[6];
                    r_execute[i] <= csr.csr_wr_data[2];
                    r_store[i]   <= csr.csr_wr_data[1];
                    r_load[i]    <= csr.csr_wr_data[0];
                    if (dbg_mode) begin
                        r_dmode[i] <= csr.csr_wr_data[27];
                    end
                    if ((i % 2) == 0) begin
                        r_chain[i] <= csr.csr_wr_data[11];
                    end
                end
                if (w_wr_tdata2 && (r_tselect == 2'(i))) begin
                    r_tdata2[i] <= csr.csr_wr_data;
                end
            end
            r_hit     <= w_hit_nxt;
            r_hit_out <= w_q;
            r_dbg_req <= w_dbg_nxt;
            r_brk_req <= w_brk_nxt;
        end
    end

    assign w_tdata1_rd = {4'd2, r_dmode[r_tselect], 6'h1F, r_hit[r_tselect], r_select[r_tselect],
                          6'b0, r_action[r_tselect], r_chain[r_tselect], 3'b0, r_match[r_tselect],
                          r_m[r_tselect], 3'b0, r_execute[r_tselect], r_store[r_tselect],
                          r_load[r_tselect]};

    always_comb begin
        csr.csr_rd_data = '0;
        case (csr.csr_rd_addr)
            ADDR_TSELECT: csr.csr_rd_data = {30'b0, r_tselect};
            ADDR_TDATA1:  csr.csr_rd_data = w_tdata1_rd;
            ADDR_TDATA2:  csr.csr_rd_data = r_tdata2[r_tselect];
            default:      csr.csr_rd_data = '0;
        endcase
    end

    always_comb begin
        trigger_pkt_any = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            trigger_pkt_any[i].select  = r_select[i];
            trigger_pkt_any[i].match   = r_match[i];
            trigger_pkt_any[i].m       = r_m[i];
            trigger_pkt_any[i].tdata2  = r_tdata2[i];
            trigger_pkt_any[i].execute = r_execute[i] & ~dbg_mode;
            trigger_pkt_any[i].store   = r_store[i] & ~dbg_mode;
            trigger_pkt_any[i].load    = r_load[i] & ~dbg_mode;
        end
    end

    assign trigger_hit_r   = r_hit_out;
    assign dbg_trigger_req = r_dbg_req;
    assign brkpt_exc_req   = r_brk_req;

endmodule
